// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL coarse-code control path.
//   CODE_W  : width of the binary DCO code
//   THERM_W : width of the thermometer control word (one bit per delay stage)
//   state_e : controller FSM states
//   dir_e   : decision direction (NONE doubles as HOLD for a single decision)
package adpll_pkg;

    localparam int unsigned CODE_W  = 7;
    localparam int unsigned THERM_W = 128;

    typedef enum logic [1:0] {IDLE, SEARCH, TRACK} state_e;

    typedef enum logic [1:0] {NONE, UP, DN} dir_e;

    // Both or neither asserted is treated as no move.
    function automatic dir_e decode_dir(input logic up, input logic dn);
        if (up && !dn) begin
            return UP;
        end else if (dn && !up) begin
            return DN;
        end
        return NONE;
    endfunction

endpackage

// File: rtl/therm_dec.sv
// 7-to-128 thermometer decoder for the DCO coarse control word.
//   i_code  : binary code, 0..127
//   o_therm : o_therm[i] = (i <= i_code); bit 0 is always set
module therm_dec
    import adpll_pkg::*;
(
    input  logic [CODE_W-1:0]  i_code,
    output logic [THERM_W-1:0] o_therm
);

    always_comb begin
        o_therm = '0;
        for (int i = 0; i < THERM_W; i++) begin
            o_therm[i] = (i <= int'(i_code));
        end
    end

endmodule

// File: rtl/dco_code_ctrl.sv
// Frequency-acquisition / tracking controller for the ADPLL DCO coarse code.
// Binary search from INIT_CODE with halving steps, then +/-1 tracking with a
// reversal-based lock detector.
//   i_clk        : reference/decision clock
//   i_reset      : synchronous, active-high reset
//   i_enable     : 1 = run loop, 0 = return to IDLE and stop the DCO
//   i_pd_valid   : decision strobe; i_pd_up/i_pd_dn valid only when high
//   i_pd_up      : DCO too slow, raise code
//   i_pd_dn      : DCO too fast, lower code
//   o_dco_run    : DCO run/stop (0 = stopped)
//   o_code       : current binary code
//   o_therm      : thermometer decode of o_code
//   o_searching  : high while in SEARCH
//   o_locked     : lock indicator
module dco_code_ctrl
    import adpll_pkg::*;
#(
    parameter int unsigned INIT_CODE  = 64,
    parameter int unsigned INIT_STEP  = 32,
    parameter int unsigned SETTLE_CYC = 3,
    parameter int unsigned LOCK_CNT   = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_pd_valid,
    input  logic               i_pd_up,
    input  logic               i_pd_dn,
    output logic               o_dco_run,
    output logic [CODE_W-1:0]  o_code,
    output logic [THERM_W-1:0] o_therm,
    output logic               o_searching,
    output logic               o_locked
);

    localparam int unsigned SETTLE_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam int unsigned LOCK_W   = (LOCK_CNT > 0) ? $clog2(LOCK_CNT + 1) : 1;

    localparam logic [CODE_W-1:0]   CODE_INIT  = CODE_W'(INIT_CODE);
    localparam logic [CODE_W-1:0]   STEP_INIT  = CODE_W'(INIT_STEP);
    localparam logic [CODE_W-1:0]   CODE_MAX   = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYC);
    localparam logic [LOCK_W-1:0]   LOCK_MAX   = LOCK_W'(LOCK_CNT);

    state_e              r_state,    w_state_nxt;
    logic [CODE_W-1:0]   r_code,     w_code_nxt;
    logic [CODE_W-1:0]   r_step,     w_step_nxt;
    logic [SETTLE_W-1:0] r_settle,   w_settle_nxt;
    logic [LOCK_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;
    dir_e                r_last_dir, w_last_dir_nxt;

    logic                w_decision;
    dir_e                w_dir;
    logic [CODE_W-1:0]   w_delta;
    logic [CODE_W:0]     w_sum;
    logic [CODE_W:0]     w_diff;
    logic [CODE_W-1:0]   w_code_up;
    logic [CODE_W-1:0]   w_code_dn;
    logic [LOCK_W-1:0]   w_lock_inc;

    assign w_decision = i_pd_valid && (r_settle == '0);
    assign w_dir      = decode_dir(i_pd_up, i_pd_dn);
    assign w_delta    = (r_state == SEARCH) ? r_step : CODE_W'(1);

    // One extra bit so overflow/underflow is visible and can be clamped.
    assign w_sum      = {1'b0, r_code} + {1'b0, w_delta};
    assign w_diff     = {1'b0, r_code} - {1'b0, w_delta};
    assign w_code_up  = w_sum[CODE_W] ? CODE_MAX : w_sum[CODE_W-1:0];
    assign w_code_dn  = w_diff[CODE_W] ? '0 : w_diff[CODE_W-1:0];
    assign w_lock_inc = (r_lock_cnt == LOCK_MAX) ? r_lock_cnt : r_lock_cnt + LOCK_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_step_nxt     = r_step;
        w_settle_nxt   = r_settle;
        w_lock_cnt_nxt = r_lock_cnt;
        w_last_dir_nxt = r_last_dir;

        if (!i_enable) begin
            w_state_nxt    = IDLE;
            w_code_nxt     = CODE_INIT;
            w_step_nxt     = STEP_INIT;
            w_settle_nxt   = '0;
            w_lock_cnt_nxt = '0;
            w_last_dir_nxt = NONE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt  = SEARCH;
                    w_settle_nxt = SETTLE_MAX;
                end
                SEARCH, TRACK: begin
                    if (w_decision) begin
                        w_settle_nxt = SETTLE_MAX;
                        if (w_dir == UP) begin
                            w_code_nxt = w_code_up;
                        end else if (w_dir == DN) begin
                            w_code_nxt = w_code_dn;
                        end

                        if (r_state == SEARCH) begin
                            w_step_nxt = r_step >> 1;
                            if (r_step == CODE_W'(1)) begin
                                w_state_nxt = TRACK;
                            end
                        end else begin
                            // HOLD or reversal builds confidence; a repeat of the
                            // previous direction means we are still slewing.
                            // The first move after entering TRACK has no history.
                            if (w_dir == NONE) begin
                                w_lock_cnt_nxt = w_lock_inc;
                            end else if (r_last_dir == w_dir) begin
                                w_lock_cnt_nxt = '0;
                            end else if (r_last_dir != NONE) begin
                                w_lock_cnt_nxt = w_lock_inc;
                            end
                            if (w_dir != NONE) begin
                                w_last_dir_nxt = w_dir;
                            end
                        end
                    end else if (r_settle != '0) begin
                        w_settle_nxt = r_settle - SETTLE_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_code     <= CODE_INIT;
            r_step     <= STEP_INIT;
            r_settle   <= '0;
            r_lock_cnt <= '0;
            r_last_dir <= NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_step     <= w_step_nxt;
            r_settle   <= w_settle_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_last_dir <= w_last_dir_nxt;
        end
    end

    assign o_dco_run   = (r_state != IDLE);
    assign o_searching = (r_state == SEARCH);
    assign o_locked    = (r_lock_cnt == LOCK_MAX);
    assign o_code      = r_code;

    therm_dec u_therm_dec (
        .i_code  (r_code),
        .o_therm (o_therm)
    );

endmodule

// File: tb/tb_dco_code_ctrl.sv
// Scoreboard bench for dco_code_ctrl: the driver advances a behavioural model
// and queues the expected outputs; the monitor compares after every edge.
module tb_dco_code_ctrl;

    localparam int INIT_CODE  = 64;
    localparam int INIT_STEP  = 32;
    localparam int SETTLE_CYC = 3;
    localparam int LOCK_CNT   = 4;

    localparam int M_IDLE   = 0;
    localparam int M_SEARCH = 1;
    localparam int M_TRACK  = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         pd_valid = 1'b0;
    logic         pd_up = 1'b0;
    logic         pd_dn = 1'b0;
    logic         dco_run;
    logic [6:0]   code;
    logic [127:0] therm;
    logic         searching;
    logic         locked;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int code;
        bit run;
        bit srch;
        bit lock;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    int m_mode   = M_IDLE;
    int m_code   = INIT_CODE;
    int m_step   = INIT_STEP;
    int m_settle = 0;
    int m_lock   = 0;
    int m_last   = 0;   // +1 up, -1 down, 0 none

    always #5 clk = ~clk;

    dco_code_ctrl #(
        .INIT_CODE  (INIT_CODE),
        .INIT_STEP  (INIT_STEP),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_CNT   (LOCK_CNT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_pd_valid  (pd_valid),
        .i_pd_up     (pd_up),
        .i_pd_dn     (pd_dn),
        .o_dco_run   (dco_run),
        .o_code      (code),
        .o_therm     (therm),
        .o_searching (searching),
        .o_locked    (locked)
    );

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > 127) return 127;
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit pv, input bit up,
                              input bit dn);
        int dir;
        if (rst || !en) begin
            m_mode = M_IDLE; m_code = INIT_CODE; m_step = INIT_STEP;
            m_settle = 0; m_lock = 0; m_last = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_SEARCH;
            m_settle = SETTLE_CYC;
        end else if (pv && m_settle == 0) begin
            dir = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
            m_settle = SETTLE_CYC;
            if (m_mode == M_SEARCH) begin
                m_code = clamp(m_code + dir * m_step);
                if (m_step == 1) m_mode = M_TRACK;
                m_step = m_step / 2;
            end else begin
                m_code = clamp(m_code + dir);
                if (dir == 0 || (m_last != 0 && m_last != dir)) begin
                    m_lock = (m_lock < LOCK_CNT) ? m_lock + 1 : LOCK_CNT;
                end else if (m_last == dir) begin
                    m_lock = 0;
                end
                if (dir != 0) m_last = dir;
            end
        end else if (m_settle > 0) begin
            m_settle = m_settle - 1;
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit pv, input bit up, input bit dn);
        exp_t e;
        @(negedge clk);
        reset = rst; enable = en; pd_valid = pv; pd_up = up; pd_dn = dn;
        model_step(rst, en, pv, up, dn);
        e.code = m_code;
        e.run  = (m_mode != M_IDLE);
        e.srch = (m_mode == M_SEARCH);
        e.lock = (m_mode == M_TRACK) && (m_lock == LOCK_CNT);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
    endtask

    // Enable, then wait out the initial settle window.
    task automatic start();
        cycle(0, 1, 0, 0, 0);
        repeat (SETTLE_CYC) cycle(0, 1, 0, 0, 0);
    endtask

    task automatic strobe(input bit up, input bit dn);
        cycle(0, 1, 1, up, dn);
        repeat (SETTLE_CYC) cycle(0, 1, 0, 0, 0);
    endtask

    // Directed absolute checks on the state reached after the last driven cycle.
    task automatic check(input string name, input int want_code, input bit want_run,
                         input bit want_srch, input bit want_lock);
        @(posedge clk);
        #1;
        n_tests++;
        if (int'(code) != want_code || dco_run != want_run || searching != want_srch ||
            locked != want_lock) begin
            n_fail++;
            $display("FAIL %s: got code=%0d run=%0b srch=%0b lock=%0b, want code=%0d run=%0b srch=%0b lock=%0b",
                     name, code, dco_run, searching, locked, want_code, want_run, want_srch,
                     want_lock);
        end
    endtask

    task automatic check_therm(input string name, input logic [127:0] want);
        @(posedge clk);
        #1;
        n_tests++;
        if (therm !== want) begin
            n_fail++;
            $display("FAIL %s: got therm=%h, want %h", name, therm, want);
        end
    endtask

    // Monitor: one expected entry per clock edge.
    initial begin
        exp_t e;
        logic [127:0] et;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                et = '0;
                for (int i = 0; i < 128; i++) et[i] = (i <= e.code);
                n_tests++;
                if (int'(code) != e.code || dco_run != e.run || searching != e.srch ||
                    locked != e.lock || therm !== et) begin
                    n_fail++;
                    $display("FAIL scoreboard @%0t: got code=%0d run=%0b srch=%0b lock=%0b therm=%h, want code=%0d run=%0b srch=%0b lock=%0b therm=%h",
                             $time, code, dco_run, searching, locked, therm, e.code, e.run,
                             e.srch, e.lock, et);
                end
            end
        end
    end

    initial begin
        logic [127:0] all_ones;
        logic [127:0] one_hot0;
        bit en, rst, pv;
        all_ones = '1;
        one_hot0 = 128'h1;

        // Reset state
        do_reset();
        check("reset", INIT_CODE, 0, 0, 0);

        // Search saturating up
        start();
        check("search_start", INIT_CODE, 1, 1, 0);
        repeat (6) strobe(1, 0);
        check("search_up_127", 127, 1, 0, 0);
        repeat (2) strobe(1, 0);
        check("track_up_hold", 127, 1, 0, 0);
        check_therm("therm_all_ones", all_ones);

        // Search saturating down
        do_reset();
        start();
        repeat (6) strobe(0, 1);
        check("search_dn_1", 1, 1, 0, 0);
        strobe(0, 1);
        check("track_dn_0", 0, 1, 0, 0);
        check_therm("therm_min", one_hot0);
        strobe(0, 1);
        check("track_dn_hold", 0, 1, 0, 0);

        // Lock: search to 100 (U,H,H,U,H,H), then alternate
        do_reset();
        start();
        strobe(1, 0); strobe(1, 1); strobe(0, 0); strobe(1, 0); strobe(1, 1); strobe(0, 0);
        check("search_to_100", 100, 1, 0, 0);
        strobe(1, 0); strobe(0, 1); strobe(1, 0); strobe(0, 1);
        check("three_reversals", 100, 1, 0, 0);
        strobe(1, 0);
        check("locked_4th_rev", 101, 1, 0, 1);
        strobe(0, 1);
        check("locked_holds", 100, 1, 0, 1);
        strobe(1, 0);
        check("up_after_dn", 101, 1, 0, 1);
        strobe(1, 0);
        check("unlock_2nd_up", 102, 1, 0, 0);

        // Settle filtering and HOLD halving
        do_reset();
        start();
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("settle_drop", 96, 1, 1, 0);
        strobe(1, 1);
        strobe(1, 0);
        check("hold_halves", 104, 1, 1, 0);

        // enable drop mid-search
        do_reset();
        start();
        strobe(1, 0); strobe(1, 0);
        check("at_112", 112, 1, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check("enable_drop", INIT_CODE, 0, 0, 0);

        // reset mid-search
        start();
        strobe(1, 0); strobe(1, 0);
        cycle(1, 1, 1, 1, 0);
        check("reset_mid", INIT_CODE, 0, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 99) < 98);
            pv  = ($urandom_range(0, 99) < 35);
            cycle(rst, en, pv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Drain
        cycle(0, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
